data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised single-port data memory for the processor's load/store path. It has a valid/ready request channel, a registered read response with backpressure, per-byte write enables and out-of-range detection. After every reset a hardware sequencer clears the whole array, one word per cycle, so no multi-port clear logic is needed. The block sits between the execute stage's load/store unit and the data array, and replaces the fixed 16-bit × 64-word memory.

## Interface
Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 8, request address width.
- DEPTH, 64, number of words; 2 ≤ DEPTH ≤ 2^ADDR_W.
- BE_W, DATA_W/8, byte-enable width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  BE_W  byte enables for writes; bit i covers bits [8i+7:8i]; ignored on reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  request address ≥ DEPTH.
- init_busy  out  1  clear sequencer running.

## Operation
- Two-state FSM: INIT and RUN.
- Reset has priority over everything. While reset is high: state = INIT, clear counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. Any pending response is discarded.
- INIT behaviour:
  - Each cycle with reset low writes 0 to mem[counter] and increments the counter.
  - On the edge that clears mem[DEPTH-1], the state goes to RUN.
  - init_busy = (state == INIT); req_ready = 0.
- RUN: req_ready = !rsp_valid || rsp_ready. This is combinational from registered state and rsp_ready, and never depends on req_valid.
- Accept means req_valid && req_ready at a rising edge. Every accepted request produces exactly one response.
- Write, addr < DEPTH: for each i with req_be[i] = 1, mem[addr] byte i ← req_wdata byte i. Other bytes are unchanged. Response: rdata = 0, err = 0.
- Write with req_be = 0: memory is unchanged and the write is still acknowledged.
- Read, addr < DEPTH: response rdata = mem[addr] as it stood before the accept edge, err = 0.
- Any access with addr ≥ DEPTH: no memory change, rdata = 0, err = 1.
- The response register updates on accept. It holds its value until rsp_valid && rsp_ready, then clears rsp_valid, unless a new accept occurs on the same edge.
- Only one request per cycle, so there are no read/write collisions inside a cycle.

## Timing
- Reset values: rsp_valid 0, rsp_rdata 0, rsp_err 0, init_busy 1, req_ready 0.
- Clear duration: init_busy falls exactly DEPTH cycles after the first rising edge with reset low. With DEPTH = 64, req_ready can first be 1 in cycle 65 after reset release.
- Reset asserted mid-INIT restarts the counter at 0. Reset mid-RUN re-enters INIT, and the entire array is cleared again.
- Latency: a request accepted at edge N gives rsp_valid = 1 from edge N to the edge where it is consumed. This is one cycle minimum.
- Throughput: with rsp_ready held at 1, one request is accepted every cycle and there are no bubbles.
- Backpressure: with rsp_valid = 1 and rsp_ready = 0, req_ready = 0. rsp_rdata and rsp_err must hold stable.
- Read-after-write: a write accepted at edge N followed by a read of the same address accepted at edge N+1 returns the written data.
- Address compare uses the full ADDR_W bits with no truncation. For example, with DEPTH = 64, addr 0x40 is an error, not an alias of address 0.

## Test plan
- Clear check: write 0xFFFF to all 64 words, pulse reset, wait for init_busy to fall, read all 64 words -> every read returns 0x0000 with rsp_err = 0. init_busy falls exactly 64 cycles after reset release.
- Byte enables: write 0x1234 to addr 5 with be = 11, write 0xABCD to addr 5 with be = 01, read addr 5 -> 0x12CD. A write with be = 00 is acked and the next read still gives 0x12CD.
- Back-to-back: with rsp_ready = 1, issue a write of 0xBEEF to addr 7 then a read of addr 7 on consecutive cycles -> req_ready stays 1, and the read response is 0xBEEF one cycle after its accept.
- Backpressure: hold rsp_ready = 0 with a read response of 0x0042 pending -> req_ready = 0 and the response stays stable for 5 cycles. Raising rsp_ready gives consumption on that edge and allows a new accept on the same edge.
- Out-of-range: with DEPTH = 64, write 0x5555 to addr 0x40 and read addr 0xFF -> both responses have rsp_err = 1 and rdata = 0. A read of addr 0x00 is unchanged.
- Reset mid-operation: assert reset for 1 cycle while a response is pending and again 10 cycles into INIT -> rsp_valid drops at the reset edge, and init_busy lasts a full 64 cycles after the final reset release.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port data memory for the load/store path.
// Valid/ready request channel, registered response with backpressure,
// per-byte write enables, out-of-range flagging, and a post-reset
// sequencer that zeroes the array one word per cycle.
module data_mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              init_busy_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);
  // One extra bit so DEPTH == 2^ADDR_W is representable in the compare.
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              clr_we;
  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  // Full-width compare: addresses at or above DEPTH never alias low words.
  assign in_range = ({1'b0, req_addr_i} < DEPTH_C);
  assign idx      = req_addr_i[IDX_W-1:0];
  assign accept   = req_valid_i && req_ready_o;

  // Next-state, clear counter and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_we      = 1'b0;
    req_ready_o = 1'b0;
    init_busy_o = (state_q == ST_INIT);
    case (state_q)
      ST_INIT: begin
        clr_we = !reset_i;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // Gated by reset so nothing is offered while reset is held.
        req_ready_o = !reset_i && (!rsp_valid_q || rsp_ready_i);
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State register and clear counter; reset restarts the clear sweep.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data array: sequencer zeroes during INIT, byte-masked writes in RUN.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem_q[cnt_q] <= '0;
    end else if (accept && req_we_i && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be_i[b]) mem_q[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
      end
    end
  end

  // Response register: loads on accept, drops valid once consumed.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= !in_range;
      rsp_rdata_q <= (!req_we_i && in_range) ? mem_q[idx] : '0;
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: directed scenarios plus randomized traffic
// checked against an array-based memory model.
module tb_data_mem_ctrl;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 64;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid, rsp_ready, rsp_err, init_busy;
  logic [DATA_W-1:0] rsp_rdata;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] model [DEPTH];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .init_busy_o(init_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: word memory with byte masking; out-of-range is an error.
  task automatic model_apply(input logic we, input int addr, input logic [DATA_W-1:0] wd,
                             input logic [BE_W-1:0] be,
                             output logic [DATA_W-1:0] er, output logic ee);
    er = '0;
    ee = (addr >= DEPTH);
    if (!ee) begin
      if (we) begin
        for (int b = 0; b < BE_W; b++)
          if (be[b]) model[addr][8*b +: 8] = wd[8*b +: 8];
      end else begin
        er = model[addr];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Issue one request with rsp_ready high; return the response seen right after accept.
  task automatic send(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                      input logic [BE_W-1:0] be,
                      output logic ov, output logic [DATA_W-1:0] od, output logic oe);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    rsp_ready = 1'b1;
    #1;
    while (!req_ready && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL send_timeout: req_ready stayed %b, required 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    ov = rsp_valid; od = rsp_rdata; oe = rsp_err;
  endtask

  // Pulse reset for `cyc` cycles, then count cycles until init_busy falls.
  task automatic do_reset(input int cyc, output int n);
    reset = 1'b1; req_valid = 1'b0;
    repeat (cyc) tick();
    reset = 1'b0;
    model_clear();
    n = 0;
    while (init_busy && n < 300) begin tick(); n++; end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
    tests++; if (rsp_rdata !== '0) begin fails++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", rsp_err); end
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b want 1", init_busy); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    reset = 1'b0; model_clear();
    n = 0;
    while (init_busy && n < 300) begin
      if (req_ready !== 1'b0) begin
        tests++; fails++; $display("FAIL init_ready: got %b want 0 at cycle %0d", req_ready, n);
      end
      tick(); n++;
    end
    tests++; if (n != DEPTH) begin fails++; $display("FAIL init_len: got %0d want %0d", n, DEPTH); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL run_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_clear();
    logic v, e; logic [DATA_W-1:0] d; int n; int bad = 0;
    for (int i = 0; i < DEPTH; i++) send(1'b1, ADDR_W'(i), 16'hFFFF, 2'b11, v, d, e);
    do_reset(1, n);
    tests++; if (n != DEPTH) begin fails++; $display("FAIL clear_len: got %0d want %0d", n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b0, ADDR_W'(i), '0, '0, v, d, e);
      tests++;
      if (v !== 1'b1 || d !== 16'h0000 || e !== 1'b0) begin
        fails++; bad++;
        $display("FAIL clear_read[%0d]: got v=%b d=%h e=%b want v=1 d=0000 e=0", i, v, d, e);
      end
    end
  endtask

  task automatic test_byte_en();
    logic v, e; logic [DATA_W-1:0] d;
    send(1'b1, 8'd5, 16'h1234, 2'b11, v, d, e);
    tests++; if (v !== 1'b1 || d !== '0 || e !== 1'b0) begin fails++; $display("FAIL be_wr_ack: got v=%b d=%h e=%b want 1/0000/0", v, d, e); end
    send(1'b1, 8'd5, 16'hABCD, 2'b01, v, d, e);
    send(1'b0, 8'd5, '0, '0, v, d, e);
    tests++; if (d !== 16'h12CD) begin fails++; $display("FAIL be_merge: got %h want 12cd", d); end
    send(1'b1, 8'd5, 16'hFFFF, 2'b00, v, d, e);
    tests++; if (v !== 1'b1 || e !== 1'b0) begin fails++; $display("FAIL be_zero_ack: got v=%b e=%b want 1/0", v, e); end
    send(1'b0, 8'd5, '0, '0, v, d, e);
    tests++; if (d !== 16'h12CD) begin fails++; $display("FAIL be_zero_keep: got %h want 12cd", d); end
    model[5] = 16'h12CD;
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd7; req_wdata = 16'hBEEF; req_be = 2'b11;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready0: got %b want 1", req_ready); end
    tick();
    req_we = 1'b0; req_wdata = '0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready1: got %b want 1", req_ready); end
    tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== '0) begin fails++; $display("FAIL b2b_wr_rsp: got v=%b d=%h want 1/0000", rsp_valid, rsp_rdata); end
    tick();
    req_valid = 1'b0;
    tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF || rsp_err !== 1'b0) begin
      fails++; $display("FAIL b2b_raw: got v=%b d=%h e=%b want 1/beef/0", rsp_valid, rsp_rdata, rsp_err);
    end
    model[7] = 16'hBEEF;
    tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    logic v, e; logic [DATA_W-1:0] d;
    send(1'b1, 8'd9, 16'h0042, 2'b11, v, d, e);
    model[9] = 16'h0042;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd9;
    tick();
    req_addr = 8'd5;   // next request waits behind the stalled response
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 16'h0042 || rsp_err !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h e=%b want 0/1/0042/0", i, req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== model[5]) begin
      fails++; $display("FAIL bp_next: got v=%b d=%h want 1/%h", rsp_valid, rsp_rdata, model[5]);
    end
  endtask

  task automatic test_out_of_range();
    logic v, e; logic [DATA_W-1:0] d;
    send(1'b1, 8'h40, 16'h5555, 2'b11, v, d, e);
    tests++; if (v !== 1'b1 || e !== 1'b1 || d !== '0) begin fails++; $display("FAIL oor_wr: got v=%b d=%h e=%b want 1/0000/1", v, d, e); end
    send(1'b0, 8'hFF, '0, '0, v, d, e);
    tests++; if (v !== 1'b1 || e !== 1'b1 || d !== '0) begin fails++; $display("FAIL oor_rd: got v=%b d=%h e=%b want 1/0000/1", v, d, e); end
    send(1'b0, 8'h00, '0, '0, v, d, e);
    tests++; if (e !== 1'b0 || d !== model[0]) begin fails++; $display("FAIL oor_alias: got d=%h e=%b want %h/0", d, e, model[0]); end
  endtask

  task automatic test_random();
    logic v, e, we, ee; logic [DATA_W-1:0] d, wd, er; logic [BE_W-1:0] be; logic [ADDR_W-1:0] a;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(DEPTH, 255)) : ADDR_W'($urandom_range(0, 15));
      wd = DATA_W'($urandom);
      be = BE_W'($urandom);
      model_apply(we, int'(a), wd, be, er, ee);
      send(we, a, wd, be, v, d, e);
      tests++;
      if (v !== 1'b1 || d !== er || e !== ee) begin
        fails++;
        $display("FAIL rand[%0d] we=%b a=%h: got v=%b d=%h e=%b want 1/%h/%b", i, we, a, v, d, e, er, ee);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  task automatic test_reset_mid();
    logic v, e; logic [DATA_W-1:0] d; int n;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd3;
    tick();
    req_valid = 1'b0;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mid_pending: got %b want 1", rsp_valid); end
    reset = 1'b1;
    tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_drop: got %b want 0", rsp_valid); end
    reset = 1'b0;
    repeat (10) tick();
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", init_busy); end
    do_reset(1, n);
    tests++; if (n != DEPTH) begin fails++; $display("FAIL mid_len: got %0d want %0d", n, DEPTH); end
    for (int i = 0; i < 16; i++) begin
      send(1'b0, ADDR_W'(i), '0, '0, v, d, e);
      tests++; if (d !== 16'h0000 || e !== 1'b0) begin fails++; $display("FAIL mid_clear[%0d]: got %h/%b want 0000/0", i, d, e); end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_byte_en();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
